// File: rtl/icache_upstream_txdat_buf_if.sv
// ---------------------------------------------------------------------------
// icache_upstream_txdat_buf_if
//
// Response-beat handshake between the upstream TXDAT line buffer and its
// consumer. Each buffered cache line is presented as two half-line beats
// (lineA half first, then lineB half) under a valid/ready handshake.
//
// Signals
//   out_vld   : a response beat is valid (buffer -> consumer)
//   out_rdy   : the consumer accepts the beat (consumer -> buffer)
//   out_data  : beat payload, LINE_W/2 bits
//   out_txnid : transaction id of the head entry
//   out_last  : the current beat is the final (second) beat of its line
//
// Modports
//   master : the buffer side, drives the beat
//   slave  : the consumer side, drives out_rdy
// ---------------------------------------------------------------------------
`ifndef ICACHE_REQ_TXNID_WIDTH
`define ICACHE_REQ_TXNID_WIDTH 8
`endif

interface icache_upstream_txdat_buf_if #(
  parameter int unsigned LINE_W  = 512,
  parameter int unsigned TXNID_W = `ICACHE_REQ_TXNID_WIDTH
);
  logic                  out_vld;
  logic                  out_rdy;
  logic [LINE_W/2-1:0]   out_data;
  logic [TXNID_W-1:0]    out_txnid;
  logic                  out_last;

  modport master (
    output out_vld,
    output out_data,
    output out_txnid,
    output out_last,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  out_data,
    input  out_txnid,
    input  out_last,
    output out_rdy
  );
endinterface

// File: rtl/icache_upstream_txdat_buf.sv
// ---------------------------------------------------------------------------
// icache_upstream_txdat_buf
//
// Buffers full-width data-array read lines for the upstream TXDAT channel and
// streams each one out as two half-line beats. Reads are credit-controlled:
// the arbiter may issue a read only while stored entries plus reads still in
// flight leave room for the returning line, so under correct use nothing is
// ever dropped. A line arriving while the buffer is full (and not draining in
// the same cycle) is discarded and flagged through a sticky overflow_err.
//
// Parameters
//   DEPTH   : number of line entries (power of two, >= 2)
//   LINE_W  : width of a data-array read line
//   TXNID_W : width of the request transaction id
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   rd_issue     : a data-array read is accepted this cycle (data 1 cycle later)
//   rd_allow     : the arbiter may issue a data-array read this cycle
//   in_vld       : read line present this cycle (no back-pressure)
//   in_data      : read line, {lineB half, lineA half}
//   in_txnid     : txnid of the read line
//   rsp          : response beat handshake (master modport)
//   occupancy    : number of stored entries
//   overflow_err : sticky, a line was dropped
// ---------------------------------------------------------------------------
`ifndef ICACHE_REQ_TXNID_WIDTH
`define ICACHE_REQ_TXNID_WIDTH 8
`endif

module icache_upstream_txdat_buf #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LINE_W  = 512,
  parameter int unsigned TXNID_W = `ICACHE_REQ_TXNID_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      rd_issue,
  output logic                      rd_allow,

  input  logic                      in_vld,
  input  logic [LINE_W-1:0]         in_data,
  input  logic [TXNID_W-1:0]        in_txnid,

  icache_upstream_txdat_buf_if.master rsp,

  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      overflow_err
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HALF_W = LINE_W / 2;

  typedef enum logic {
    BEAT0,
    BEAT1
  } beat_e;

  // Line storage; contents are only observed while out_vld is high, so it is
  // left out of reset.
  logic [LINE_W-1:0]  line_mem  [DEPTH];
  logic [TXNID_W-1:0] txnid_mem [DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   occ_q;
  logic [CNT_W-1:0]   inflight_q;
  logic               overflow_q;
  beat_e              beat_q;
  beat_e              beat_d;

  logic               fifo_empty;
  logic               fifo_full;
  logic               head_vld;
  logic               beat_fire;
  logic               pop;
  logic               push;
  logic               drop;
  logic [CNT_W:0]     credit_sum;

  // -------------------------------------------------------------------------
  // Occupancy-derived status
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == CNT_W'(DEPTH));
    head_vld   = !fifo_empty;
    beat_fire  = head_vld && rsp.out_rdy;
  end

  // -------------------------------------------------------------------------
  // Beat pointer: next state and beat outputs
  // -------------------------------------------------------------------------
  always_comb begin
    beat_d        = beat_q;
    pop           = 1'b0;
    rsp.out_vld   = head_vld;
    rsp.out_last  = 1'b0;
    rsp.out_data  = line_mem[rd_ptr][HALF_W-1:0];
    rsp.out_txnid = txnid_mem[rd_ptr];

    case (beat_q)
      BEAT0: begin
        if (beat_fire) begin
          beat_d = BEAT1;
        end
      end
      BEAT1: begin
        rsp.out_last = 1'b1;
        rsp.out_data = line_mem[rd_ptr][LINE_W-1:HALF_W];
        if (beat_fire) begin
          beat_d = BEAT0;
          pop    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= BEAT0;
    end else begin
      beat_q <= beat_d;
    end
  end

  // -------------------------------------------------------------------------
  // Write acceptance. A full buffer still accepts a line when the head is
  // popped in the same cycle: the freed slot is the one being written, and
  // the old head is consumed on that same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    push = in_vld && (!fifo_full || pop);
    drop = in_vld && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      line_mem[wr_ptr]  <= in_data;
      txnid_mem[wr_ptr] <= in_txnid;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, occupancy, credit counter and sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   occ_q <= occ_q + CNT_W'(1);
        2'b01:   occ_q <= occ_q - CNT_W'(1);
        default: occ_q <= occ_q;
      endcase

      // Saturating in both directions: an unsolicited line with no read in
      // flight leaves the count at zero rather than wrapping.
      if (rd_issue && !in_vld && (inflight_q != '1)) begin
        inflight_q <= inflight_q + CNT_W'(1);
      end else if (in_vld && !rd_issue && (inflight_q != '0)) begin
        inflight_q <= inflight_q - CNT_W'(1);
      end

      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Credit check: one extra bit so the sum of two counters cannot wrap.
  // -------------------------------------------------------------------------
  always_comb begin
    credit_sum   = {1'b0, occ_q} + {1'b0, inflight_q};
    rd_allow     = (credit_sum < (CNT_W + 1)'(DEPTH));
    occupancy    = occ_q;
    overflow_err = overflow_q;
  end

endmodule

// File: tb/tb_icache_upstream_txdat_buf.sv
// ---------------------------------------------------------------------------
// tb_icache_upstream_txdat_buf
//
// Bench for the upstream TXDAT line buffer (DEPTH=4, LINE_W=512, TXNID_W=8).
// The reference model keeps the buffered data as a queue of half-line beats:
// every stored line contributes two beats, the head beat is what the output
// must show, and a line is freed when its last beat is taken.
// ---------------------------------------------------------------------------
module tb_icache_upstream_txdat_buf;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LINE_W  = 512;
  localparam int unsigned HALF_W  = LINE_W / 2;
  localparam int unsigned TXNID_W = 8;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rd_issue;
  logic               rd_allow;
  logic               in_vld;
  logic [LINE_W-1:0]  in_data;
  logic [TXNID_W-1:0] in_txnid;
  logic [CNT_W-1:0]   occupancy;
  logic               overflow_err;

  icache_upstream_txdat_buf_if #(.LINE_W(LINE_W), .TXNID_W(TXNID_W)) ifc ();

  icache_upstream_txdat_buf #(
    .DEPTH   (DEPTH),
    .LINE_W  (LINE_W),
    .TXNID_W (TXNID_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_issue     (rd_issue),
    .rd_allow     (rd_allow),
    .in_vld       (in_vld),
    .in_data      (in_data),
    .in_txnid     (in_txnid),
    .rsp          (ifc),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [HALF_W-1:0]  d;
    logic [TXNID_W-1:0] t;
  } beat_t;

  beat_t mq[$];
  int    m_infl;
  bit    m_ovf;

  // beat accepted during the most recent cycle
  logic              acc_v;
  logic [HALF_W-1:0] acc_d;

  task automatic check(input string name, input logic [HALF_W-1:0] act,
                       input logic [HALF_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int m_occ();
    return (mq.size() + 1) / 2;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_infl = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic iss, input logic iv,
                            input logic [LINE_W-1:0] d,
                            input logic [TXNID_W-1:0] t, input logic rdy);
    int    sz;
    bit    acc;
    bit    line_done;
    beat_t b;
    sz        = mq.size();
    acc       = (sz > 0) && rdy;
    line_done = acc && (sz % 2 == 1);
    if (acc) void'(mq.pop_front());
    if (iv) begin
      if (((sz + 1) / 2 < DEPTH) || line_done) begin
        b.t = t;
        b.d = d[HALF_W-1:0];
        mq.push_back(b);
        b.d = d[LINE_W-1:HALF_W];
        mq.push_back(b);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (iss && !iv && m_infl < 2 * DEPTH - 1) m_infl++;
    else if (iv && !iss && m_infl > 0) m_infl--;
  endtask

  task automatic model_compare();
    check("model_vld", HALF_W'(ifc.out_vld), HALF_W'(mq.size() > 0));
    check("model_occupancy", HALF_W'(occupancy), HALF_W'(m_occ()));
    check("model_rd_allow", HALF_W'(rd_allow), HALF_W'(m_occ() + m_infl < DEPTH));
    check("model_overflow", HALF_W'(overflow_err), HALF_W'(m_ovf));
    if (mq.size() > 0) begin
      check("model_data", ifc.out_data, mq[0].d);
      check("model_txnid", HALF_W'(ifc.out_txnid), HALF_W'(mq[0].t));
      check("model_last", HALF_W'(ifc.out_last), HALF_W'(mq.size() % 2 == 1));
    end
  endtask

  // One clock cycle: drive inputs, update model at the edge, compare after.
  task automatic cycle(input logic iss, input logic iv,
                       input logic [LINE_W-1:0] d,
                       input logic [TXNID_W-1:0] t, input logic rdy);
    logic               stall;
    logic [HALF_W-1:0]  pd;
    logic [TXNID_W-1:0] pt;
    logic               pl;
    rd_issue    = iss;
    in_vld      = iv;
    in_data     = d;
    in_txnid    = t;
    ifc.out_rdy = rdy;
    stall = ifc.out_vld && !rdy;
    pd    = ifc.out_data;
    pt    = ifc.out_txnid;
    pl    = ifc.out_last;
    acc_v = ifc.out_vld && rdy;
    acc_d = ifc.out_data;
    @(posedge clk);
    model_edge(iss, iv, d, t, rdy);
    @(negedge clk);
    model_compare();
    if (stall) begin
      check("stall_data", ifc.out_data, pd);
      check("stall_txnid", HALF_W'(ifc.out_txnid), HALF_W'(pt));
      check("stall_last", HALF_W'(ifc.out_last), HALF_W'(pl));
    end
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    rd_issue    = 1'b0;
    in_vld      = 1'b0;
    in_data     = '0;
    in_txnid    = '0;
    ifc.out_rdy = 1'b0;
    #1;
    check("rst_vld", HALF_W'(ifc.out_vld), '0);
    check("rst_last", HALF_W'(ifc.out_last), '0);
    check("rst_rd_allow", HALF_W'(rd_allow), HALF_W'(1));
    check("rst_occupancy", HALF_W'(occupancy), '0);
    check("rst_overflow", HALF_W'(overflow_err), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] a, input logic [31:0] b);
    return {HALF_W'(b), HALF_W'(a)};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic               iss;
    logic               iv;
    logic [31:0]        da;
    logic [31:0]        db;
    logic [TXNID_W-1:0] t;
    logic               rdy;
    logic               e_vld;
    logic               e_last;
    logic [CNT_W-1:0]   e_occ;
    logic               e_allow;
    logic               e_ovf;
    logic [31:0]        e_data;
    logic [TXNID_W-1:0] e_txn;
  } vec_t;

  vec_t tbl[12];

  initial begin
    vec_t              v;
    logic [31:0]       drain_exp[8];
    logic [HALF_W-1:0] got[$];
    logic              iss;
    logic              pend;
    int                issued;
    int                written;
    int                guard;

    // single line (rows 0-3), then credit fill with out_rdy low (rows 4-11)
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  32'h0,  8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0,  8'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'hA,  32'hB,  8'd3, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'hA,  8'd3};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,  32'h0,  8'd0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 32'hB,  8'd3};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,  32'h0,  8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0,  8'd0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,  32'h0,  8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0,  8'd0};
    tbl[5]  = '{1'b0, 1'b1, 32'h11, 32'h21, 8'd1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h11, 8'd1};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,  32'h0,  8'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h11, 8'd1};
    tbl[7]  = '{1'b0, 1'b1, 32'h12, 32'h22, 8'd2, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 32'h11, 8'd1};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,  32'h0,  8'd0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 32'h11, 8'd1};
    tbl[9]  = '{1'b0, 1'b1, 32'h13, 32'h23, 8'd3, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 32'h11, 8'd1};
    tbl[10] = '{1'b1, 1'b0, 32'h0,  32'h0,  8'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 32'h11, 8'd1};
    tbl[11] = '{1'b0, 1'b1, 32'h14, 32'h24, 8'd4, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 32'h11, 8'd1};

    apply_reset();

    for (int r = 0; r < 12; r++) begin
      v = tbl[r];
      cycle(v.iss, v.iv, mk_line(v.da, v.db), v.t, v.rdy);
      check($sformatf("tbl%0d_vld", r), HALF_W'(ifc.out_vld), HALF_W'(v.e_vld));
      check($sformatf("tbl%0d_occupancy", r), HALF_W'(occupancy), HALF_W'(v.e_occ));
      check($sformatf("tbl%0d_rd_allow", r), HALF_W'(rd_allow), HALF_W'(v.e_allow));
      check($sformatf("tbl%0d_overflow", r), HALF_W'(overflow_err), HALF_W'(v.e_ovf));
      if (v.e_vld) begin
        check($sformatf("tbl%0d_last", r), HALF_W'(ifc.out_last), HALF_W'(v.e_last));
        check($sformatf("tbl%0d_data", r), ifc.out_data, HALF_W'(v.e_data));
        check($sformatf("tbl%0d_txnid", r), HALF_W'(ifc.out_txnid), HALF_W'(v.e_txn));
      end
    end

    // full and in BEAT1: take beat A of line 1 first
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    check("full_beat1_last", HALF_W'(ifc.out_last), HALF_W'(1));
    check("full_beat1_data", ifc.out_data, HALF_W'(32'h21));
    // same-cycle pop and write while full
    cycle(1'b0, 1'b1, mk_line(32'h15, 32'h25), 8'd5, 1'b1);
    check("simul_occupancy", HALF_W'(occupancy), HALF_W'(4));
    check("simul_overflow", HALF_W'(overflow_err), '0);
    check("simul_head_data", ifc.out_data, HALF_W'(32'h12));
    check("simul_rd_allow", HALF_W'(rd_allow), '0);
    // forced write while full, no pop: dropped
    cycle(1'b0, 1'b1, mk_line(32'hEE, 32'hEF), 8'h77, 1'b0);
    check("ovf_flag", HALF_W'(overflow_err), HALF_W'(1));
    check("ovf_occupancy", HALF_W'(occupancy), HALF_W'(4));
    drain_exp = '{32'h12, 32'h22, 32'h13, 32'h23, 32'h14, 32'h24, 32'h15, 32'h25};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d_data", k), ifc.out_data, HALF_W'(drain_exp[k]));
      cycle(1'b0, 1'b0, '0, '0, 1'b1);
    end
    check("drain_occupancy", HALF_W'(occupancy), '0);
    check("ovf_sticky", HALF_W'(overflow_err), HALF_W'(1));

    // back-pressure over three lines
    apply_reset();
    got.delete();
    issued = 0; written = 0; pend = 1'b0; guard = 0;
    while (got.size() < 6 && guard < 200) begin
      iss = (issued < 3) && !pend;
      cycle(iss, pend, mk_line(32'hA0 + written, 32'hB0 + written),
            TXNID_W'(10 + written), 1'($urandom % 2));
      if (pend) written++;
      if (iss) issued++;
      pend = iss;
      if (acc_v) got.push_back(acc_d);
      guard++;
    end
    check("bp_beat_count", HALF_W'(got.size()), HALF_W'(6));
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      check($sformatf("bp_beat%0d", k), got[k],
            HALF_W'((k % 2 == 0 ? 32'hA0 : 32'hB0) + k / 2));
    end

    // randomized traffic, credit-respecting reads plus occasional stray lines
    apply_reset();
    pend = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      iss = rd_allow && ($urandom % 2 == 1);
      cycle(iss, pend || ($urandom % 32 == 0),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            TXNID_W'($urandom), ($urandom % 3 != 0));
      pend = iss;
    end

    // nine streamed lines wrap both pointers twice
    apply_reset();
    got.delete();
    for (int k = 0; k < 9; k++) begin
      cycle(1'b1, 1'b0, '0, '0, 1'b1);
      if (acc_v) got.push_back(acc_d);
      cycle(1'b0, 1'b1, mk_line(32'hC00 + k, 32'hD00 + k), TXNID_W'(k), 1'b1);
      if (acc_v) got.push_back(acc_d);
    end
    guard = 0;
    while (ifc.out_vld && guard < 20) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1);
      if (acc_v) got.push_back(acc_d);
      guard++;
    end
    check("wrap_beat_count", HALF_W'(got.size()), HALF_W'(18));
    for (int k = 0; k < 18 && k < got.size(); k++) begin
      check($sformatf("wrap_beat%0d", k), got[k],
            HALF_W'((k % 2 == 0 ? 32'hC00 : 32'hD00) + k / 2));
    end

    // reset asserted mid-BEAT1
    cycle(1'b1, 1'b0, '0, '0, 1'b0);
    cycle(1'b0, 1'b1, mk_line(32'hE0, 32'hE1), 8'h55, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    check("prerst_last", HALF_W'(ifc.out_last), HALF_W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_vld", HALF_W'(ifc.out_vld), '0);
    check("midrst_rd_allow", HALF_W'(rd_allow), HALF_W'(1));
    check("midrst_occupancy", HALF_W'(occupancy), '0);
    check("midrst_last", HALF_W'(ifc.out_last), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, mk_line(32'hF0, 32'hF1), 8'h66, 1'b0);
    check("postrst_occupancy", HALF_W'(occupancy), HALF_W'(1));
    check("postrst_data", ifc.out_data, HALF_W'(32'hF0));
    check("postrst_rd_allow", HALF_W'(rd_allow), HALF_W'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "timeout");
  end

endmodule
